external_io_fifo: RTL and testbench

//   Host-facing SPI front end for the shapool core: a parametrised successor to external_io.
//   SPI0 is write-only and loads the job configuration. SPI1 loads the device configuration
//   and reads back results. Results come from a RESULT_DEPTH-entry FIFO filled on each

---
 rtl/external_io_fifo.sv | 180 ++++++++++++++++++
 tb/tb_external_io_fifo.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/external_io_fifo.sv
// Host SPI front end for the shapool core: SPI0 loads the job configuration, SPI1 loads the
// device configuration and drains a small FIFO of results captured on each shapool success.
module external_io_fifo #(
   parameter int JOB_CONFIG_WIDTH    = 8,
   parameter int DEVICE_CONFIG_WIDTH = 8,
   parameter int RESULT_DATA_WIDTH   = 16,
   parameter int RESULT_DEPTH        = 4,
   parameter logic [DEVICE_CONFIG_WIDTH-1:0] DEVICE_CONFIG_RESET = '0
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           sck0,
   input  logic                           sdi0,
   input  logic                           cs0_n,
   input  logic                           sck1,
   input  logic                           sdi1,
   output logic                           sdo1,
   input  logic                           cs1_n,
   output logic [DEVICE_CONFIG_WIDTH-1:0] device_config,
   output logic [JOB_CONFIG_WIDTH-1:0]    job_config,
   output logic                           job_valid,
   input  logic [RESULT_DATA_WIDTH-1:0]   shapool_result,
   input  logic                           shapool_success,
   output logic                           result_ready,
   output logic [$clog2(RESULT_DEPTH):0]  result_count
);

   localparam int TX_WIDTH = 8 + RESULT_DATA_WIDTH;
   localparam int PTR_W    = $clog2(RESULT_DEPTH);
   localparam int CNT_W    = PTR_W + 1;
   localparam int JCNT_W   = $clog2(JOB_CONFIG_WIDTH + 2);
   localparam int SCNT_W   = $clog2(TX_WIDTH + 1);

   localparam int SCK0 = 0;
   localparam int SDI0 = 1;
   localparam int CS0  = 2;
   localparam int SCK1 = 3;
   localparam int SDI1 = 4;
   localparam int CS1  = 5;

   // sync1 is the synchronised level, sync2 its previous value for edge detection
   logic [5:0] pins, sync0, sync1, sync2, rise, fall;
   assign pins = {cs1_n, sdi1, sck1, cs0_n, sdi0, sck0};
   assign rise = sync1 & ~sync2;
   assign fall = ~sync1 & sync2;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync0 <= '0;
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync0 <= pins;
         sync1 <= sync0;
         sync2 <= sync1;
      end
   end

   logic succ_q, succ_q2, push_req;
   assign push_req = succ_q & ~succ_q2;

   always_ff @(posedge clk) begin
      if (reset) begin
         succ_q  <= 1'b0;
         succ_q2 <= 1'b0;
      end else begin
         succ_q  <= shapool_success;
         succ_q2 <= succ_q;
      end
   end

   // ---------------- SPI0: job configuration ----------------
   logic                        arm0;
   logic [JOB_CONFIG_WIDTH-1:0] job_shift;
   logic [JCNT_W-1:0]           job_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         arm0       <= 1'b0;
         job_shift  <= '0;
         job_cnt    <= '0;
         job_config <= '0;
         job_valid  <= 1'b0;
      end else begin
         job_valid <= 1'b0;
         if (sync1[CS0]) arm0 <= 1'b1;
         if (arm0) begin
            if (fall[CS0]) begin
               job_shift <= '0;
               job_cnt   <= '0;
            end else if (rise[CS0]) begin
               if (job_cnt == JCNT_W'(JOB_CONFIG_WIDTH)) begin
                  job_config <= job_shift;
                  job_valid  <= 1'b1;
               end
            end else if (!sync1[CS0] && rise[SCK0]) begin
               job_shift <= {job_shift[JOB_CONFIG_WIDTH-2:0], sync1[SDI0]};
               if (job_cnt != JCNT_W'(JOB_CONFIG_WIDTH + 1)) job_cnt <= job_cnt + JCNT_W'(1);
            end
         end
      end
   end

   // ---------------- Result FIFO ----------------
   logic [RESULT_DATA_WIDTH-1:0] mem [RESULT_DEPTH];
   logic [PTR_W-1:0]             wr_ptr, rd_ptr;
   logic                         overflow;
   logic                         full, empty, pop_req, push_ok;

   assign full    = (result_count == CNT_W'(RESULT_DEPTH));
   assign empty   = (result_count == '0);
   assign push_ok = push_req & (~full | pop_req);
   assign result_ready = ~empty;

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= shapool_result;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         result_count <= '0;
         overflow     <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop_req) rd_ptr <= rd_ptr + PTR_W'(1);
         if (push_ok && !pop_req)      result_count <= result_count + CNT_W'(1);
         else if (!push_ok && pop_req) result_count <= result_count - CNT_W'(1);
         if (pop_req)                  overflow <= 1'b0;
         else if (push_req && full)    overflow <= 1'b1;
      end
   end

   // ---------------- SPI1: device configuration and result readback ----------------
   logic                         arm1;
   logic [TX_WIDTH-1:0]          tx, rx;
   logic [SCNT_W-1:0]            spi1_cnt;
   logic                         load_nonempty;
   logic [RESULT_DATA_WIDTH-1:0] head_or_zero;
   logic [31:0]                  count_ext;
   logic [6:0]                   count_sat;

   assign head_or_zero = empty ? '0 : mem[rd_ptr];
   assign count_ext    = 32'(result_count);
   assign count_sat    = (count_ext > 32'd127) ? 7'd127 : count_ext[6:0];
   assign pop_req      = arm1 & rise[CS1] & (spi1_cnt == SCNT_W'(TX_WIDTH)) & load_nonempty;
   assign sdo1         = ~sync1[CS1] & tx[TX_WIDTH-1];

   always_ff @(posedge clk) begin
      if (reset) begin
         arm1          <= 1'b0;
         tx            <= '0;
         rx            <= '0;
         spi1_cnt      <= '0;
         load_nonempty <= 1'b0;
         device_config <= DEVICE_CONFIG_RESET;
      end else begin
         if (sync1[CS1]) arm1 <= 1'b1;
         if (arm1) begin
            if (fall[CS1]) begin
               tx            <= {overflow, count_sat, head_or_zero};
               load_nonempty <= ~empty;
               rx            <= '0;
               spi1_cnt      <= '0;
            end else if (rise[CS1]) begin
               if (spi1_cnt == SCNT_W'(DEVICE_CONFIG_WIDTH))
                  device_config <= rx[DEVICE_CONFIG_WIDTH-1:0];
            end else if (!sync1[CS1]) begin
               if (rise[SCK1]) begin
                  rx <= {rx[TX_WIDTH-2:0], sync1[SDI1]};
                  if (spi1_cnt != SCNT_W'(TX_WIDTH)) spi1_cnt <= spi1_cnt + SCNT_W'(1);
               end
               if (fall[SCK1]) tx <= {tx[TX_WIDTH-2:0], 1'b0};
            end
         end
      end
   end

endmodule

// File: tb/tb_external_io_fifo.sv
// Bench for external_io_fifo: directed scenarios followed by randomised SPI/result traffic,
// all checked against a queue-based model of the host-visible behaviour.
module tb_external_io_fifo;

   localparam int H     = 6;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        sck0, sdi0, cs0_n, sck1, sdi1, cs1_n;
   logic        sdo1;
   logic [7:0]  device_config, job_config;
   logic        job_valid;
   logic [15:0] shapool_result;
   logic        shapool_success;
   logic        result_ready;
   logic [2:0]  result_count;

   always #5 clk = ~clk;

   external_io_fifo dut (
      .clk(clk), .reset(reset),
      .sck0(sck0), .sdi0(sdi0), .cs0_n(cs0_n),
      .sck1(sck1), .sdi1(sdi1), .sdo1(sdo1), .cs1_n(cs1_n),
      .device_config(device_config), .job_config(job_config), .job_valid(job_valid),
      .shapool_result(shapool_result), .shapool_success(shapool_success),
      .result_ready(result_ready), .result_count(result_count)
   );

   int checks = 0;
   int passed = 0;
   int pulse_total = 0;

   always @(negedge clk) if (job_valid) pulse_total++;

   // host-visible model
   logic [15:0] exp_q[$];
   bit          exp_ovf;
   logic [7:0]  exp_job, exp_dev;

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic model_push(input logic [15:0] d);
      if (exp_q.size() < DEPTH) exp_q.push_back(d);
      else exp_ovf = 1'b1;
   endtask

   task automatic model_read(output logic [23:0] e);
      logic [15:0] head;
      head = (exp_q.size() != 0) ? exp_q[0] : 16'h0000;
      e = {exp_ovf, 7'(exp_q.size()), head};
      if (exp_q.size() != 0) begin
         void'(exp_q.pop_front());
         exp_ovf = 1'b0;
      end
   endtask

   task automatic spi0_frame(input logic [15:0] data, input int nbits);
      cs0_n = 1'b0;
      wait_clk(H);
      for (int i = 0; i < nbits; i++) begin
         sdi0 = data[nbits-1-i];
         wait_clk(H);
         sck0 = 1'b1;
         wait_clk(H);
         sck0 = 1'b0;
      end
      wait_clk(H);
      cs0_n = 1'b1;
      wait_clk(2*H);
   endtask

   task automatic spi1_frame(input logic [31:0] data, input int nbits, input bit succ_at_end,
                             output logic [31:0] rx);
      rx = '0;
      cs1_n = 1'b0;
      wait_clk(H);
      for (int i = 0; i < nbits; i++) begin
         sdi1 = data[nbits-1-i];
         wait_clk(H);
         rx = {rx[30:0], sdo1};
         sck1 = 1'b1;
         wait_clk(H);
         sck1 = 1'b0;
      end
      wait_clk(H);
      cs1_n = 1'b1;
      if (succ_at_end) begin
         // success edge reaches the FIFO on the same clock as the pop commit
         wait_clk(1);
         shapool_success = 1'b1;
         wait_clk(H);
         shapool_success = 1'b0;
      end
      wait_clk(2*H);
   endtask

   task automatic push_result(input logic [15:0] d);
      shapool_result  = d;
      shapool_success = 1'b1;
      wait_clk(3);
      shapool_success = 1'b0;
      wait_clk(3);
      model_push(d);
   endtask

   task automatic read_and_check(input string tag);
      logic [31:0] rx;
      logic [23:0] e;
      spi1_frame(32'h0, 24, 1'b0, rx);
      model_read(e);
      check(tag, rx, {8'h00, e});
      check({tag, "_count"}, result_count, exp_q.size());
   endtask

   initial begin
      logic [31:0] rx;
      logic [23:0] e;
      int          p0, op, len;
      logic [15:0] d;

      reset = 1'b1;
      sck0 = 0; sdi0 = 0; cs0_n = 1;
      sck1 = 0; sdi1 = 0; cs1_n = 1;
      shapool_result = '0; shapool_success = 0;
      exp_ovf = 0; exp_job = 0; exp_dev = 0;
      wait_clk(3);
      reset = 1'b0;
      wait_clk(1);
      check("rst_job_config", job_config, 0);
      check("rst_job_valid", job_valid, 0);
      check("rst_device_config", device_config, 0);
      check("rst_sdo1", sdo1, 0);
      check("rst_result_ready", result_ready, 0);
      check("rst_result_count", result_count, 0);
      wait_clk(5);

      // job write, then a short frame that must be discarded
      p0 = pulse_total;
      spi0_frame(16'hAA, 8);
      exp_job = 8'hAA;
      check("job_aa", job_config, 8'hAA);
      check("job_aa_pulse", pulse_total - p0, 1);
      p0 = pulse_total;
      spi0_frame(16'h55, 7);
      check("job_short", job_config, exp_job);
      check("job_short_pulse", pulse_total - p0, 0);

      // device configuration leaves the FIFO alone
      spi1_frame(32'h5C, 8, 1'b0, rx);
      exp_dev = 8'h5C;
      check("dev_5c", device_config, 8'h5C);
      check("dev_5c_count", result_count, 0);

      // single result readback, then an empty read
      push_result(16'h4141);
      check("one_count", result_count, 1);
      check("one_ready", result_ready, 1);
      spi1_frame(32'h0, 24, 1'b0, rx);
      model_read(e);
      check("read_4141_literal", rx, 32'h0001_4141);
      check("read_4141_model", rx, {8'h00, e});
      check("read_4141_count", result_count, 0);
      read_and_check("read_empty");
      check("read_empty_ready", result_ready, 0);

      // overflow: five pushes into four entries
      for (int i = 1; i <= 5; i++) push_result(16'(i));
      check("ovf_count", result_count, 4);
      spi1_frame(32'h0, 24, 1'b0, rx);
      model_read(e);
      check("ovf_read1_literal", rx, 32'h0084_0001);
      check("ovf_read1_model", rx, {8'h00, e});
      spi1_frame(32'h0, 24, 1'b0, rx);
      model_read(e);
      check("ovf_read2_literal", rx, 32'h0003_0002);
      check("ovf_read2_model", rx, {8'h00, e});

      // simultaneous push and pop while full
      push_result(16'h0006);
      push_result(16'h0007);
      check("sim_full_count", result_count, 4);
      shapool_result = 16'h0008;
      spi1_frame(32'h0, 24, 1'b1, rx);
      model_read(e);
      model_push(16'h0008);
      check("sim_read", rx, {8'h00, e});
      check("sim_count", result_count, 4);
      read_and_check("sim_no_ovf");
      while (exp_q.size() != 0) read_and_check("drain");

      // reset in the middle of an SPI0 frame
      p0 = pulse_total;
      cs0_n = 1'b0;
      wait_clk(H);
      for (int i = 0; i < 4; i++) begin
         sdi0 = i[0];
         wait_clk(H);
         sck0 = 1'b1;
         if (i == 3) begin
            wait_clk(2);
            reset = 1'b1;
            wait_clk(2);
            reset = 1'b0;
            exp_q.delete(); exp_ovf = 0; exp_job = 0; exp_dev = 0;
         end
         wait_clk(H);
         sck0 = 1'b0;
      end
      for (int i = 0; i < 4; i++) begin
         sdi0 = 1'b1;
         wait_clk(H);
         sck0 = 1'b1;
         wait_clk(H);
         sck0 = 1'b0;
      end
      wait_clk(H);
      cs0_n = 1'b1;
      wait_clk(2*H);
      check("midrst_pulse", pulse_total - p0, 0);
      check("midrst_job", job_config, 0);
      check("midrst_dev", device_config, 0);
      p0 = pulse_total;
      spi0_frame(16'h3C, 8);
      exp_job = 8'h3C;
      check("midrst_next_job", job_config, exp_job);
      check("midrst_next_pulse", pulse_total - p0, 1);

      // randomised traffic
      for (int it = 0; it < 24; it++) begin
         op = $urandom_range(0, 3);
         case (op)
            0: begin
               len = $urandom_range(7, 9);
               d   = 16'($urandom);
               p0  = pulse_total;
               spi0_frame(d, len);
               if (len == 8) exp_job = d[7:0];
               check("rnd_job", job_config, exp_job);
               check("rnd_job_pulse", pulse_total - p0, (len == 8) ? 1 : 0);
            end
            1: begin
               len = $urandom_range(7, 9);
               d   = 16'($urandom);
               spi1_frame({16'h0, d}, len, 1'b0, rx);
               if (len == 8) exp_dev = d[7:0];
               check("rnd_dev", device_config, exp_dev);
               check("rnd_dev_count", result_count, exp_q.size());
            end
            2: begin
               push_result(16'($urandom));
               check("rnd_push_count", result_count, exp_q.size());
            end
            default: read_and_check("rnd_read");
         endcase
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
